pipelined_shifter: RTL and testbench

- Parametrised, pipelined successor to the team's 32-bit combinational right shifter.
- Logarithmic shifter: one pipeline stage per shift-amount bit.
- Supports logical right, arithmetic right, logical left and rotate right.
- Valid/ready handshake on both sides; sits between the ALU operand mux and the result writeback stage, with throughput of one operation per cycle.

---
 rtl/pipelined_shifter.sv | 163 ++++++++++++++++
 tb/tb_pipelined_shifter.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_shifter.sv
`default_nettype none
// ============================================================================
// Module   : pipelined_shifter
// Summary  : Parametrised logarithmic shifter, one pipeline stage per
//            shift-amount bit. Supports SRL, SRA, SLL and ROR with a
//            valid/ready handshake on both sides and a global stall.
// Options  : define PIPELINED_SHIFTER_STICKY_EN to add the out_sticky port
//            (OR of all bits discarded by SRL/SRA/SLL).
// Revision : 1.0  initial release
// ============================================================================
module pipelined_shifter #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [SHAMT_W-1:0] in_shamt,
  input  logic [1:0]         in_op,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data
`ifdef PIPELINED_SHIFTER_STICKY_EN
  ,
  output logic               out_sticky
`endif
);

  localparam logic [1:0] c_OP_SRL = 2'b00;
  localparam logic [1:0] c_OP_SRA = 2'b01;
  localparam logic [1:0] c_OP_SLL = 2'b10;

  // Elaboration-time sanity checks on the configuration.
  if (WIDTH < 4 || (WIDTH & (WIDTH - 1)) != 0) begin : g_chk_width
    $error("pipelined_shifter: WIDTH must be a power of two and at least 4");
  end
  if (SHAMT_W != $clog2(WIDTH)) begin : g_chk_shamt
    $error("pipelined_shifter: SHAMT_W must equal clog2(WIDTH)");
  end

  // The whole pipeline moves together: either the output slot is empty or it
  // is being drained this cycle. Bubbles are deliberately not collapsed.
  logic w_adv;
  assign w_adv    = !out_valid || out_ready;
  assign in_ready = w_adv;

  genvar gi;
  for (gi = 0; gi < SHAMT_W; gi++) begin : g_stage
    // Distance this stage shifts by, and how many shift-amount bits are
    // still pending at this stage's input (bit 0 of those is ours).
    localparam int SH = 1 << gi;
    localparam int SW = SHAMT_W - gi;

    logic             w_src_valid;
    logic [WIDTH-1:0] w_src_data;
    logic [SW-1:0]    w_src_shamt;
    logic [1:0]       w_src_op;
    logic [WIDTH-1:0] w_shifted;
    logic             r_valid;
    logic [WIDTH-1:0] r_data;
`ifdef PIPELINED_SHIFTER_STICKY_EN
    logic             w_src_sticky;
    logic             w_lost;
    logic             r_sticky;
`endif

    // Stage 0 takes the request port; later stages take the previous stage's
    // register. Already-consumed shift-amount bits are dropped along the way.
    if (gi == 0) begin : g_head
      assign w_src_valid = in_valid;
      assign w_src_data  = in_data;
      assign w_src_shamt = in_shamt;
      assign w_src_op    = in_op;
`ifdef PIPELINED_SHIFTER_STICKY_EN
      assign w_src_sticky = 1'b0;
`endif
    end else begin : g_body
      assign w_src_valid = g_stage[gi-1].r_valid;
      assign w_src_data  = g_stage[gi-1].r_data;
      assign w_src_shamt = g_stage[gi-1].g_carry.r_shamt;
      assign w_src_op    = g_stage[gi-1].g_carry.r_op;
`ifdef PIPELINED_SHIFTER_STICKY_EN
      assign w_src_sticky = g_stage[gi-1].r_sticky;
`endif
    end

    // Conditional shift by SH. For SRA the current MSB is still the
    // operand's original sign bit, because earlier SRA stages only ever
    // replicated it.
    always_comb begin
      w_shifted = w_src_data;
      if (w_src_shamt[0]) begin
        case (w_src_op)
          c_OP_SRL: w_shifted = {{SH{1'b0}}, w_src_data[WIDTH-1:SH]};
          c_OP_SRA: w_shifted = {{SH{w_src_data[WIDTH-1]}}, w_src_data[WIDTH-1:SH]};
          c_OP_SLL: w_shifted = {w_src_data[WIDTH-SH-1:0], {SH{1'b0}}};
          default:  w_shifted = {w_src_data[SH-1:0], w_src_data[WIDTH-1:SH]};
        endcase
      end
    end

`ifdef PIPELINED_SHIFTER_STICKY_EN
    // Bits this stage pushes off the end of the word; rotate loses nothing.
    always_comb begin
      w_lost = 1'b0;
      if (w_src_shamt[0]) begin
        case (w_src_op)
          c_OP_SRL, c_OP_SRA: w_lost = |w_src_data[SH-1:0];
          c_OP_SLL:           w_lost = |w_src_data[WIDTH-1:WIDTH-SH];
          default:            w_lost = 1'b0;
        endcase
      end
    end

    // Sticky accumulates across stages alongside the data.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_sticky <= 1'b0;
      end else if (w_adv) begin
        r_sticky <= w_src_sticky | w_lost;
      end
    end
`endif

    // Stage register for valid and data; holds while the pipeline is stalled.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_valid <= 1'b0;
        r_data  <= '0;
      end else if (w_adv) begin
        r_valid <= w_src_valid;
        r_data  <= w_shifted;
      end
    end

    // Control that later stages still need; the final stage has no consumer.
    if (gi < SHAMT_W - 1) begin : g_carry
      logic [SW-2:0] r_shamt;
      logic [1:0]    r_op;

      // Forward the remaining shift-amount bits and the operation.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_shamt <= '0;
          r_op    <= 2'b00;
        end else if (w_adv) begin
          r_shamt <= w_src_shamt[SW-1:1];
          r_op    <= w_src_op;
        end
      end
    end
  end

  assign out_valid = g_stage[SHAMT_W-1].r_valid;
  assign out_data  = g_stage[SHAMT_W-1].r_data;
`ifdef PIPELINED_SHIFTER_STICKY_EN
  assign out_sticky = g_stage[SHAMT_W-1].r_sticky;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipelined_shifter.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipelined_shifter
// Summary  : Self-checking bench for pipelined_shifter (WIDTH=32 and WIDTH=8
//            instances) against an arithmetic reference model.
// Revision : 1.0  initial release
// ============================================================================
module tb_pipelined_shifter;

  logic        clk = 1'b0;
  logic        rst_n;

  logic        in_valid, in_ready, out_valid, out_ready, out_sticky;
  logic [31:0] in_data, out_data;
  logic [4:0]  in_shamt;
  logic [1:0]  in_op;

  logic        in8_valid, in8_ready, out8_valid, out8_ready, out8_sticky;
  logic [7:0]  in8_data, out8_data;
  logic [2:0]  in8_shamt;
  logic [1:0]  in8_op;

  int checks   = 0;
  int failures = 0;

  logic [63:0] exp_d[$];
  logic [63:0] obs_d[$];
  logic        exp_s[$];
  logic        obs_s[$];

  always #5 clk = ~clk;

  pipelined_shifter #(.WIDTH(32), .SHAMT_W(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_shamt(in_shamt), .in_op(in_op),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
`ifdef PIPELINED_SHIFTER_STICKY_EN
    , .out_sticky(out_sticky)
`endif
  );

  pipelined_shifter #(.WIDTH(8), .SHAMT_W(3)) dut8 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in8_valid), .in_ready(in8_ready), .in_data(in8_data),
    .in_shamt(in8_shamt), .in_op(in8_op),
    .out_valid(out8_valid), .out_ready(out8_ready), .out_data(out8_data)
`ifdef PIPELINED_SHIFTER_STICKY_EN
    , .out_sticky(out8_sticky)
`endif
  );

`ifndef PIPELINED_SHIFTER_STICKY_EN
  assign out_sticky  = 1'b0;
  assign out8_sticky = 1'b0;
`endif

  // Reference model: the shift result computed directly on a w-bit word.
  function automatic logic [63:0] ref_data(input logic [63:0] d, input int s,
                                           input logic [1:0] op, input int w);
    logic [63:0] mask, x, r;
    mask = (64'd1 << w) - 64'd1;
    x    = d & mask;
    case (op)
      2'b00: r = x >> s;
      2'b01: r = x[w-1] ? ((x >> s) | (mask & ~(mask >> s))) : (x >> s);
      2'b10: r = (x << s) & mask;
      default: r = ((x >> s) | (x << (w - s))) & mask;
    endcase
    return r;
  endfunction

  // Reference model: were any ones discarded off the end of the word?
  function automatic logic ref_sticky(input logic [63:0] d, input int s,
                                      input logic [1:0] op, input int w);
    logic [63:0] x;
    x = d & ((64'd1 << w) - 64'd1);
    case (op)
      2'b00, 2'b01: return (x & ((64'd1 << s) - 64'd1)) != 64'd0;
      2'b10:        return (s == 0) ? 1'b0 : ((x >> (w - s)) != 64'd0);
      default:      return 1'b0;
    endcase
  endfunction

  task automatic clear_queues();
    exp_d.delete(); exp_s.delete(); obs_d.delete(); obs_s.delete();
  endtask

  // One clock cycle on the 32-bit instance: drive, record what is accepted
  // (as model predictions) and what is delivered, then advance one edge.
  task automatic drive_cycle(input bit v, input logic [31:0] d, input logic [4:0] s,
                             input logic [1:0] op, input bit rdy, output bit acc);
    in_valid = v; in_data = d; in_shamt = s; in_op = op; out_ready = rdy;
    #1;
    acc = v && in_ready;
    if (out_valid && out_ready) begin
      obs_d.push_back({32'h0, out_data});
      obs_s.push_back(out_sticky);
    end
    if (acc) begin
      exp_d.push_back(ref_data({32'h0, d}, int'(s), op, 32));
      exp_s.push_back(ref_sticky({32'h0, d}, int'(s), op, 32));
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 0; in_data = '0; in_shamt = '0; in_op = '0; out_ready = 0;
    in8_valid = 0; in8_data = '0; in8_shamt = '0; in8_op = '0; out8_ready = 0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++; if (out_data !== 32'h0) begin failures++; $display("FAIL reset_out_data: got %h expected 0", out_data); end
    checks++; if (out_sticky !== 1'b0) begin failures++; $display("FAIL reset_out_sticky: got %b expected 0", out_sticky); end
    checks++; if (out8_valid !== 1'b0 || out8_data !== 8'h0) begin failures++; $display("FAIL reset_w8: got valid=%b data=%h expected 0/00", out8_valid, out8_data); end
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL post_reset_valid: got %b expected 0", out_valid); end
  endtask

  task automatic test_srl_latency();
    bit acc;
    int n;
    drive_cycle(1, 32'h30004638, 5'd2, 2'b00, 1, acc);
    checks++; if (!acc) begin failures++; $display("FAIL srl_accept1: got 0 expected 1"); end
    drive_cycle(1, 32'h01400052, 5'd1, 2'b00, 1, acc);
    checks++; if (!acc) begin failures++; $display("FAIL srl_accept2: got 0 expected 1"); end
    in_valid = 0;
    n = 2;
    while (!out_valid && n < 20) begin @(posedge clk); #1; n++; end
    checks++; if (n != 5) begin failures++; $display("FAIL srl_latency: got %0d edges expected 5", n); end
    checks++; if (out_data !== 32'h0C00118E) begin failures++; $display("FAIL srl_first: got %h expected 0c00118e", out_data); end
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b1 || out_data !== 32'h00A00029) begin failures++; $display("FAIL srl_second: got valid=%b data=%h expected 1/00a00029", out_valid, out_data); end
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL srl_drained: got %b expected 0", out_valid); end
  endtask

  task automatic test_mixed_modes();
    logic [31:0] vd[5] = '{32'h80000000, 32'h00000001, 32'h00000001, 32'h12345678, 32'hDEADBEEF};
    int          vs[5] = '{4, 31, 1, 8, 0};
    logic [1:0]  vo[5] = '{2'b01, 2'b10, 2'b11, 2'b11, 2'b00};
    logic [31:0] ve[5] = '{32'hF8000000, 32'h80000000, 32'h80000000, 32'h78123456, 32'hDEADBEEF};
    bit acc;
    int b;
    clear_queues();
    for (int i = 0; i < 5; i++) drive_cycle(1, vd[i], 5'(vs[i]), vo[i], 1, acc);
    b = 0;
    while (obs_d.size() < 5 && b < 20) begin drive_cycle(0, '0, '0, '0, 1, acc); b++; end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (i >= obs_d.size()) begin failures++; $display("FAIL mixed_%0d: got nothing expected %h", i, ve[i]); end
      else if (obs_d[i] !== {32'h0, ve[i]}) begin failures++; $display("FAIL mixed_%0d: got %h expected %h", i, obs_d[i][31:0], ve[i]); end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] d[6];
    logic [4:0]  s[6];
    logic [1:0]  o[6];
    logic [31:0] frozen;
    int idx;
    bit acc;
    clear_queues();
    for (int i = 0; i < 6; i++) begin
      d[i] = $urandom() ^ (32'h11111111 * i);
      s[i] = 5'($urandom_range(1, 31));
      o[i] = 2'($urandom_range(0, 3));
    end
    idx = 0;
    for (int c = 0; c < 6; c++) begin
      drive_cycle(1, d[idx], s[idx], o[idx], 0, acc);
      if (acc) idx++;
    end
    checks++; if (idx != 5) begin failures++; $display("FAIL bp_accepted: got %0d expected 5", idx); end
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready: got %b expected 0", in_ready); end
    checks++; if (out_valid !== 1'b1 || out_data !== exp_d[0][31:0]) begin failures++; $display("FAIL bp_head: got valid=%b data=%h expected 1/%h", out_valid, out_data, exp_d[0][31:0]); end
    frozen = out_data;
    for (int c = 0; c < 4; c++) begin
      drive_cycle(1, d[5], s[5], o[5], 0, acc);
      checks++; if (acc || out_valid !== 1'b1 || out_data !== frozen) begin failures++; $display("FAIL bp_frozen_%0d: got acc=%b valid=%b data=%h expected 0/1/%h", c, acc, out_valid, out_data, frozen); end
    end
    for (int k = 0; k < 6; k++) begin
      drive_cycle(idx < 6, d[idx < 6 ? idx : 5], s[idx < 6 ? idx : 5], o[idx < 6 ? idx : 5], 1, acc);
      if (acc) idx++;
      checks++; if (obs_d.size() != k + 1) begin failures++; $display("FAIL bp_rate_%0d: got %0d results expected %0d", k, obs_d.size(), k + 1); end
    end
    checks++; if (exp_d.size() != 6 || obs_d.size() != 6) begin failures++; $display("FAIL bp_count: got %0d/%0d expected 6/6", exp_d.size(), obs_d.size()); end
    for (int i = 0; i < 6 && i < obs_d.size() && i < exp_d.size(); i++) begin
      checks++; if (obs_d[i] !== exp_d[i]) begin failures++; $display("FAIL bp_order_%0d: got %h expected %h", i, obs_d[i][31:0], exp_d[i][31:0]); end
    end
  endtask

  task automatic test_random_stream();
    bit acc, v, rdy, pre_stall;
    logic [31:0] pre_data;
    int b;
    clear_queues();
    for (int c = 0; c < 300; c++) begin
      v   = ($urandom_range(0, 99) < 70);
      rdy = ($urandom_range(0, 99) < 60);
      pre_stall = out_valid && !rdy;
      pre_data  = out_data;
      drive_cycle(v, $urandom(), 5'($urandom_range(0, 31)), 2'($urandom_range(0, 3)), rdy, acc);
      if (pre_stall) begin
        checks++; if (out_valid !== 1'b1 || out_data !== pre_data) begin failures++; $display("FAIL rand_hold_%0d: got valid=%b data=%h expected 1/%h", c, out_valid, out_data, pre_data); end
      end
    end
    b = 0;
    while (obs_d.size() < exp_d.size() && b < 50) begin drive_cycle(0, '0, '0, '0, 1, acc); b++; end
    checks++; if (obs_d.size() != exp_d.size()) begin failures++; $display("FAIL rand_count: got %0d expected %0d", obs_d.size(), exp_d.size()); end
    for (int i = 0; i < obs_d.size() && i < exp_d.size(); i++) begin
      checks++; if (obs_d[i] !== exp_d[i]) begin failures++; $display("FAIL rand_data_%0d: got %h expected %h", i, obs_d[i][31:0], exp_d[i][31:0]); end
`ifdef PIPELINED_SHIFTER_STICKY_EN
      checks++; if (obs_s[i] !== exp_s[i]) begin failures++; $display("FAIL rand_sticky_%0d: got %b expected %b", i, obs_s[i], exp_s[i]); end
`endif
    end
    for (int c = 0; c < 10; c++) begin
      drive_cycle(0, '0, '0, '0, 1, acc);
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL idle_valid_%0d: got %b expected 0", c, out_valid); end
    end
  endtask

  task automatic test_async_reset();
    bit acc;
    int n;
    clear_queues();
    for (int i = 0; i < 3; i++) drive_cycle(1, $urandom() | 32'h1, 5'd0, 2'b00, 0, acc);
    for (int i = 0; i < 3; i++) drive_cycle(0, '0, '0, '0, 0, acc);
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL arst_setup: got %b expected 1", out_valid); end
    #3;
    rst_n = 1'b0;
    in_valid = 1; in_data = $urandom();
    #1;
    checks++; if (out_valid !== 1'b0 || out_data !== 32'h0) begin failures++; $display("FAIL arst_immediate: got valid=%b data=%h expected 0/0", out_valid, out_data); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL arst_in_ready: got %b expected 1", in_ready); end
    @(posedge clk); #2;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL arst_held: got %b expected 0", out_valid); end
    rst_n = 1'b1;
    in_valid = 0; out_ready = 1;
    @(posedge clk); #1;
    clear_queues();
    for (int c = 0; c < 8; c++) begin
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL arst_stale_%0d: got %b expected 0", c, out_valid); end
      drive_cycle(0, '0, '0, '0, 1, acc);
    end
    drive_cycle(1, 32'hA5A50F0F, 5'd4, 2'b00, 1, acc);
    in_valid = 0;
    n = 1;
    while (!out_valid && n < 20) begin @(posedge clk); #1; n++; end
    checks++; if (n != 5) begin failures++; $display("FAIL arst_latency: got %0d edges expected 5", n); end
    checks++; if (out_data !== 32'h0A5A50F0) begin failures++; $display("FAIL arst_result: got %h expected 0a5a50f0", out_data); end
    @(posedge clk); #1;
    clear_queues();
  endtask

`ifdef PIPELINED_SHIFTER_STICKY_EN
  task automatic test_sticky();
    logic [31:0] vd[4] = '{32'h0000000F, 32'h00000010, 32'hF0000000, 32'h0000000F};
    int          vs[4] = '{2, 4, 4, 2};
    logic [1:0]  vo[4] = '{2'b00, 2'b00, 2'b10, 2'b11};
    logic [31:0] ve[4] = '{32'h00000003, 32'h00000001, 32'h00000000, 32'hC0000003};
    logic        vt[4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    bit acc;
    int b;
    clear_queues();
    for (int i = 0; i < 4; i++) drive_cycle(1, vd[i], 5'(vs[i]), vo[i], 1, acc);
    b = 0;
    while (obs_d.size() < 4 && b < 20) begin drive_cycle(0, '0, '0, '0, 1, acc); b++; end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (i >= obs_d.size()) begin failures++; $display("FAIL sticky_%0d: got nothing expected %h/%b", i, ve[i], vt[i]); end
      else if (obs_d[i] !== {32'h0, ve[i]} || obs_s[i] !== vt[i]) begin failures++; $display("FAIL sticky_%0d: got %h/%b expected %h/%b", i, obs_d[i][31:0], obs_s[i], ve[i], vt[i]); end
    end
  endtask
`endif

  task automatic test_width8();
    logic [7:0] ed[$];
    logic [7:0] od[$];
    logic       es[$];
    logic       os[$];
    logic [7:0] d;
    logic [2:0] s;
    logic [1:0] o;
    int n;
    out8_ready = 1;
    in8_valid = 1; in8_data = 8'h90; in8_shamt = 3'd3; in8_op = 2'b01;
    #1;
    checks++; if (in8_ready !== 1'b1) begin failures++; $display("FAIL w8_in_ready: got %b expected 1", in8_ready); end
    @(posedge clk); #1;
    in8_data = 8'h81; in8_shamt = 3'd1; in8_op = 2'b11;
    @(posedge clk); #1;
    in8_valid = 0;
    n = 2;
    while (!out8_valid && n < 20) begin @(posedge clk); #1; n++; end
    checks++; if (n != 3) begin failures++; $display("FAIL w8_latency: got %0d edges expected 3", n); end
    checks++; if (out8_data !== 8'hF2) begin failures++; $display("FAIL w8_sra: got %h expected f2", out8_data); end
    @(posedge clk); #1;
    checks++; if (out8_valid !== 1'b1 || out8_data !== 8'hC0) begin failures++; $display("FAIL w8_ror: got valid=%b data=%h expected 1/c0", out8_valid, out8_data); end
    @(posedge clk); #1;
    for (int c = 0; c < 40; c++) begin
      in8_valid = (c < 24);
      d = 8'($urandom()); s = 3'($urandom_range(0, 7)); o = 2'($urandom_range(0, 3));
      in8_data = d; in8_shamt = s; in8_op = o;
      #1;
      if (out8_valid) begin od.push_back(out8_data); os.push_back(out8_sticky); end
      if (in8_valid && in8_ready) begin
        ed.push_back(8'(ref_data({56'h0, d}, int'(s), o, 8)));
        es.push_back(ref_sticky({56'h0, d}, int'(s), o, 8));
      end
      @(posedge clk); #1;
    end
    in8_valid = 0;
    checks++; if (od.size() != ed.size()) begin failures++; $display("FAIL w8_count: got %0d expected %0d", od.size(), ed.size()); end
    for (int i = 0; i < od.size() && i < ed.size(); i++) begin
      checks++; if (od[i] !== ed[i]) begin failures++; $display("FAIL w8_data_%0d: got %h expected %h", i, od[i], ed[i]); end
`ifdef PIPELINED_SHIFTER_STICKY_EN
      checks++; if (os[i] !== es[i]) begin failures++; $display("FAIL w8_sticky_%0d: got %b expected %b", i, os[i], es[i]); end
`endif
    end
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_srl_latency();
    test_mixed_modes();
    test_backpressure();
    test_random_stream();
    test_async_reset();
`ifdef PIPELINED_SHIFTER_STICKY_EN
    test_sticky();
`endif
    test_width8();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
